// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register, skid buffer and redirect flush
module fetch_stage #(
    parameter int unsigned            PC_W     = 32,
    parameter logic [PC_W-1:0]        RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [PC_W-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic [6:0]      if_id_opcode
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic [PC_W-1:0]   pc_q,        pc_d;
    logic [PC_W-1:0]   target_q,    target_d;
    logic              valid_q,     valid_d;
    logic [PC_W-1:0]   id_pc_q,     id_pc_d;
    logic [31:0]       id_instr_q,  id_instr_d;
    logic              skid_full_q, skid_full_d;
    logic [PC_W-1:0]   skid_pc_q,   skid_pc_d;
    logic [31:0]       skid_instr_q, skid_instr_d;

    logic              accept;
    logic [PC_W-1:0]   redirect_aligned;
    logic [PC_W-1:0]   pc_next_seq;

    assign accept           = !valid_q || !stall;
    assign redirect_aligned = {redirect_pc[PC_W-1:2], 2'b00};
    assign pc_next_seq      = pc_q + PC_W'(4);

    // A request is kept open in DISCARD so the stale fetch can complete and be dropped.
    assign imem_req     = !rst && (state_q != HOLD);
    assign imem_addr    = pc_q;
    assign if_id_valid  = valid_q;
    assign if_id_pc     = id_pc_q;
    assign if_id_instr  = id_instr_q;
    assign if_id_opcode = id_instr_q[6:0];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        target_d     = target_q;
        valid_d      = valid_q;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;
        skid_full_d  = skid_full_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    valid_d     = 1'b0;
                    skid_full_d = 1'b0;
                    if (imem_ack) begin
                        pc_d = redirect_aligned;
                    end else begin
                        target_d = redirect_aligned;
                        state_d  = DISCARD;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_next_seq;
                    if (accept) begin
                        valid_d    = 1'b1;
                        id_pc_d    = pc_q;
                        id_instr_d = imem_rdata;
                    end else begin
                        skid_full_d  = 1'b1;
                        skid_pc_d    = pc_q;
                        skid_instr_d = imem_rdata;
                        state_d      = HOLD;
                    end
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_d        = redirect_aligned;
                    valid_d     = 1'b0;
                    skid_full_d = 1'b0;
                    state_d     = FETCH;
                end else if (!stall) begin
                    valid_d     = 1'b1;
                    id_pc_d     = skid_pc_q;
                    id_instr_d  = skid_instr_q;
                    skid_full_d = 1'b0;
                    state_d     = FETCH;
                end
            end

            DISCARD: begin
                valid_d     = 1'b0;
                skid_full_d = 1'b0;
                // A redirect arriving with the ack wins over the older target.
                if (redirect) begin
                    target_d = redirect_aligned;
                    if (imem_ack) begin
                        pc_d    = redirect_aligned;
                        state_d = FETCH;
                    end
                end else if (imem_ack) begin
                    pc_d    = target_q;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            target_q     <= '0;
            valid_q      <= 1'b0;
            id_pc_q      <= '0;
            id_instr_q   <= '0;
            skid_full_q  <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            target_q     <= target_d;
            valid_q      <= valid_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
            skid_full_q  <= skid_full_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [6:0]  if_id_opcode;

    int n_cmp;
    int n_bad;

    fetch_stage #(.PC_W(32), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_opcode (if_id_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A00093;
        return {a[24:0], 7'h33};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic ack, input logic stl, input logic rd, input logic [31:0] rpc);
        imem_ack    = ack;
        stall       = stl;
        redirect    = rd;
        redirect_pc = rpc;
        imem_rdata  = ack ? instr_at(imem_addr) : 32'hDEADBEEF;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = '0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   32'(imem_req), 32'd0);
        check("rst_valid", 32'(if_id_valid), 32'd0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_pc",    if_id_pc, 32'h0);
        check("rst_instr", if_id_instr, 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_req", 32'(imem_req), 32'd1);

        // streaming, zero-wait memory
        cycle(1, 0, 0, 0);
        check("s0_valid",  32'(if_id_valid), 32'd1);
        check("s0_pc",     if_id_pc, 32'h0);
        check("s0_instr",  if_id_instr, 32'h00A00093);
        check("s0_opcode", 32'(if_id_opcode), 32'h13);
        check("s0_addr",   imem_addr, 32'h4);
        cycle(1, 0, 0, 0);
        check("s1_pc",   if_id_pc, 32'h4);
        check("s1_addr", imem_addr, 32'h8);
        cycle(1, 0, 0, 0);
        check("s2_pc",   if_id_pc, 32'h8);
        check("s2_addr", imem_addr, 32'hC);

        // three-cycle stall: 0xC parks in the skid
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 0);
            check("stl_req",   32'(imem_req), 32'd0);
            check("stl_pc",    if_id_pc, 32'h8);
            check("stl_instr", if_id_instr, instr_at(32'h8));
            check("stl_valid", 32'(if_id_valid), 32'd1);
        end
        cycle(1, 0, 0, 0);
        check("rel_pc",    if_id_pc, 32'hC);
        check("rel_instr", if_id_instr, instr_at(32'hC));
        check("rel_addr",  imem_addr, 32'h10);
        check("rel_req",   32'(imem_req), 32'd1);

        // redirect while the fetch of 0x10 is still outstanding
        cycle(0, 0, 1, 32'h40);
        check("rd0_valid", 32'(if_id_valid), 32'd0);
        check("rd0_addr",  imem_addr, 32'h10);
        check("rd0_req",   32'(imem_req), 32'd1);
        cycle(0, 0, 0, 0);
        check("rd1_valid", 32'(if_id_valid), 32'd0);
        check("rd1_addr",  imem_addr, 32'h10);
        cycle(1, 0, 0, 0);
        check("rd2_valid", 32'(if_id_valid), 32'd0);
        check("rd2_addr",  imem_addr, 32'h40);
        cycle(1, 0, 0, 0);
        check("rd3_valid", 32'(if_id_valid), 32'd1);
        check("rd3_pc",    if_id_pc, 32'h40);
        check("rd3_instr", if_id_instr, instr_at(32'h40));

        // redirect + ack + stall, misaligned target
        cycle(1, 1, 1, 32'h103);
        check("rs_valid", 32'(if_id_valid), 32'd0);
        check("rs_addr",  imem_addr, 32'h100);
        cycle(1, 0, 0, 0);
        check("rs_pc",    if_id_pc, 32'h100);
        check("rs_nxt",   imem_addr, 32'h104);

        // wait-state memory: ack every third cycle
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 2; w++) begin
                cycle(0, 0, 0, 0);
                check("ws_valid0", 32'(if_id_valid), 32'd0);
                check("ws_addr",   imem_addr, 32'h104 + 32'(4 * k));
            end
            cycle(1, 0, 0, 0);
            check("ws_valid1", 32'(if_id_valid), 32'd1);
            check("ws_pc",     if_id_pc, 32'h104 + 32'(4 * k));
        end

        // wrap past the top of the address space; stalled-but-empty IF/ID still loads
        cycle(1, 0, 1, 32'hFFFFFFFC);
        check("wr_addr",  imem_addr, 32'hFFFFFFFC);
        check("wr_valid", 32'(if_id_valid), 32'd0);
        cycle(1, 1, 0, 0);
        check("wr_load_valid", 32'(if_id_valid), 32'd1);
        check("wr_load_pc",    if_id_pc, 32'hFFFFFFFC);
        check("wr_next_addr",  imem_addr, 32'h0);

        // async reset while in HOLD
        cycle(1, 1, 0, 0);
        check("hold_req", 32'(imem_req), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", 32'(if_id_valid), 32'd0);
        check("ar_req",   32'(imem_req), 32'd0);
        check("ar_addr",  imem_addr, 32'h0);
        check("ar_pc",    if_id_pc, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stall = 1'b0;
        #1;
        check("ar_rel_addr", imem_addr, 32'h0);
        cycle(1, 0, 0, 0);
        check("ar_first_pc",    if_id_pc, 32'h0);
        check("ar_first_instr", if_id_instr, 32'h00A00093);
        cycle(1, 0, 0, 0);
        check("ar_second_pc",   if_id_pc, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
